gmii_rx_frame_checker: RTL and testbench
========================================

# gmii_rx_frame_checker

MAC-side GMII receive checker that consumes the `rxd`/`rx_dv`/`rx_er` output of the PCS receive path. It strips the preamble and SFD and re-emits payload octets as a stream with start-of-frame and end-of-frame markers. At the end of every frame it reports the frame length, per-frame error flags and running good/bad frame counters. It sits opposite the GMII transmit source and closes the PCS loop in synthesizable form for loopback and link bring-up.

## Interface

- `OCTET_WIDTH`, 8: GMII data width.
- `LEN_WIDTH`, 16: width of the length and counter outputs.
- `MIN_LEN`, 64: minimum legal payload length in octets (SFD excluded).
- `MAX_LEN`, 1518: maximum legal payload length in octets.
- `MAX_PRE`, 7: maximum accepted count of 0x55 preamble octets.

Ports:

- `clk` in, 1: single clock. All logic is on the rising edge.
- `mr_main_reset` in, 1: reset, asynchronous assert, active-low. Deassertion is synchronous to `clk`.
- `rxd` in, OCTET_WIDTH: receive octet from the PCS.
- `rx_dv` in, 1: receive data valid.
- `rx_er` in, 1: receive error.
- `data_out` out, OCTET_WIDTH: payload octet.
- `data_valid` out, 1: `data_out` is valid this cycle.
- `sof` out, 1: first payload octet of a frame. Qualified by `data_valid`.
- `eof` out, 1: last payload octet of a frame. Qualified by `data_valid`.
- `frame_done` out, 1: one-cycle pulse at the end of every frame, including aborted frames.
- `frame_len` out, LEN_WIDTH: payload octet count. Valid with `frame_done` and held until the next `frame_done`.
- `err_pre` out, 1: bad preamble or SFD. Held like `frame_len`.
- `err_rx` out, 1: `rx_er` was seen during the frame. Held like `frame_len`.
- `err_short` out, 1: `frame_len` < MIN_LEN. Held like `frame_len`.
- `err_long` out, 1: `frame_len` > MAX_LEN. Held like `frame_len`.
- `good_cnt` out, LEN_WIDTH: count of frames ending with all four error flags low. Wraps modulo 2^LEN_WIDTH.
- `bad_cnt` out, LEN_WIDTH: count of frames ending with any error flag set. Wraps.

## Operation

Reset: every output is 0 and the FSM goes to WAIT_IDLE.

FSM states:
- **WAIT_IDLE**
  - `rx_dv`=0 → IDLE.
  - No frame is reported from this state. This guards against a reset released mid-frame.
- **IDLE**
  - `rx_dv`=1 and `rxd`=0x55 → PRE, with the preamble count set to 1.
  - `rx_dv`=1 and `rxd`=0xD5 → DATA. A zero-length preamble is legal.
  - `rx_dv`=1 with any other octet → DROP, with `err_pre` latched.
- **PRE**
  - 0x55 → stay in PRE and increment the preamble count.
  - If the count would exceed MAX_PRE → DROP, with `err_pre`.
  - 0xD5 → DATA.
  - Any other octet → DROP, with `err_pre`.
  - `rx_dv`=0 → end the frame with `err_pre` and len 0, then → IDLE.
- **DATA**
  - Each octet with `rx_dv`=1 goes into a one-octet hold register.
  - The previously held octet is emitted.
  - Length increments, saturating at all-ones.
  - `rx_dv`=0 → emit the held octet with `eof`, end the frame, → IDLE.
- **DROP**
  - No payload is emitted.
  - Length still counts octets after the error point.
  - `rx_dv`=0 → end the frame, → IDLE.

Rules in every state:
- `rx_er`=1 while `rx_dv`=1, in any state except IDLE/WAIT_IDLE, latches `err_rx`. Payload continues to be emitted.
- `rx_er`=1 with `rx_dv`=0 (false carrier or carrier extension) is ignored.
- `sof` accompanies the first emitted payload octet.
- A frame with len 0 in DATA emits no octets. It still produces `frame_done` with `err_short`.
- The end-of-frame update happens in a single cycle:
  - `frame_len` and the four error flags are registered.
  - `frame_done` pulses.
  - Exactly one of `good_cnt`/`bad_cnt` increments.
- A new frame may begin on the cycle immediately after `rx_dv` falls (no IPG required). `eof`/`frame_done` of the old frame and PRE entry of the new one coexist.

## Timing

- Payload latency: an octet sampled at edge N appears on `data_out` after edge N+2. It is held one cycle for `eof` detection, then registered.
- Last octet: sampled at edge L, with `rx_dv`=0 sampled at edge L+1. `eof`=1, `data_valid`=1 and `frame_done`=1 are all visible after edge L+2.
- `data_valid` is continuous over a frame; there are no gaps inside a frame.
- Counters and held status update on the same edge that raises `frame_done`.
- Asynchronous reset mid-frame clears everything immediately. No `frame_done` is issued for the aborted frame. If `rx_dv` is still 1 after release, the FSM waits in WAIT_IDLE.

## Test plan

- **Good frame.** Stimulus: 7×0x55, 0xD5, 64 octets 0x00..0x3F. Required:
  - 64 `data_valid` octets in order, with `sof` on 0x00 and `eof` on 0x3F.
  - `frame_done`, `frame_len`=64, no error flags.
  - `good_cnt`=1.
- **Short preamble plus back-to-back frames.** Stimulus: 1×0x55, 0xD5, 10 octets, then immediately a second frame. Required:
  - Both frames are delivered.
  - Each has `err_short`=1 and `frame_len`=10.
  - `bad_cnt`=2.
- **Bad SFD.** Stimulus: 0x55,0x55,0x5D, then 20 octets. Required:
  - No `data_valid`.
  - `err_pre`=1, `frame_len`=20, `bad_cnt`+1.
- **rx_er mid-payload.** Stimulus: 100-octet frame with `rx_er`=1 on octet 50. Required:
  - All 100 octets emitted.
  - `err_rx`=1, `frame_len`=100.
  - `rx_er` with `rx_dv`=0 between frames changes no counter.
- **Long frame.** Stimulus: 1519-octet payload. Required: `err_long`=1, `frame_len`=1519.
- **Reset mid-frame.** Stimulus: assert reset for 1 cycle at payload octet 30 while `rx_dv` stays high for 20 more octets, then a good 64-octet frame. Required:
  - Outputs are 0 immediately on assert.
  - No `frame_done` for the cut frame.
  - The next frame reports `good_cnt`=1, `frame_len`=64.

Source files
------------

// File: rtl/gmii_rx_frame_checker.sv
// GMII receive checker: strips preamble/SFD, streams payload with sof/eof and reports per-frame status.
// Payload latency is two cycles (input register + one-octet hold for eof); no backpressure, the PCS cannot be stalled.
module gmii_rx_frame_checker #(
  parameter int OCTET_WIDTH = 8,
  parameter int LEN_WIDTH   = 16,
  parameter int MIN_LEN     = 64,
  parameter int MAX_LEN     = 1518,
  parameter int MAX_PRE     = 7
) (
  input  logic                   clk,
  input  logic                   mr_main_reset,
  input  logic [OCTET_WIDTH-1:0] rxd,
  input  logic                   rx_dv,
  input  logic                   rx_er,
  output logic [OCTET_WIDTH-1:0] data_out,
  output logic                   data_valid,
  output logic                   sof,
  output logic                   eof,
  output logic                   frame_done,
  output logic [LEN_WIDTH-1:0]   frame_len,
  output logic                   err_pre,
  output logic                   err_rx,
  output logic                   err_short,
  output logic                   err_long,
  output logic [LEN_WIDTH-1:0]   good_cnt,
  output logic [LEN_WIDTH-1:0]   bad_cnt
);

  localparam int PRE_W = $clog2(MAX_PRE + 1);
  localparam logic [OCTET_WIDTH-1:0] PRE_OCTET = OCTET_WIDTH'(8'h55);
  localparam logic [OCTET_WIDTH-1:0] SFD_OCTET = OCTET_WIDTH'(8'hD5);
  localparam logic [LEN_WIDTH-1:0]   LEN_ONE   = LEN_WIDTH'(1);
  localparam logic [LEN_WIDTH-1:0]   LEN_SAT   = '1;

  typedef enum logic [2:0] {WAIT_IDLE, IDLE, PRE, DATA, DROP} state_t;

  state_t                 state_q, state_d;
  logic [OCTET_WIDTH-1:0] rxd_q, hold_dat;
  logic                   dv_q, er_q, hold_vld, sof_pend;
  logic [PRE_W-1:0]       pre_cnt;
  logic [LEN_WIDTH-1:0]   len_cnt;
  logic                   acc_err_pre, acc_err_rx;

  logic start, set_err_pre, pre_inc, len_inc, load_hold, emit, emit_eof, end_frame;
  logic fin_err_pre, fin_short, fin_long, fin_bad, in_frame;

  assign in_frame    = (state_q == PRE) || (state_q == DATA) || (state_q == DROP);
  assign fin_err_pre = acc_err_pre | set_err_pre;
  assign fin_short   = len_cnt < LEN_WIDTH'(MIN_LEN);
  assign fin_long    = len_cnt > LEN_WIDTH'(MAX_LEN);
  assign fin_bad     = fin_err_pre | acc_err_rx | fin_short | fin_long;

  always_ff @(posedge clk or negedge mr_main_reset) begin
    if (!mr_main_reset) state_q <= WAIT_IDLE;
    else                state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    start       = 1'b0;
    set_err_pre = 1'b0;
    pre_inc     = 1'b0;
    len_inc     = 1'b0;
    load_hold   = 1'b0;
    emit        = 1'b0;
    emit_eof    = 1'b0;
    end_frame   = 1'b0;
    case (state_q)
      // Watches the pin rather than the input stage so a frame cut by reset is never picked up.
      WAIT_IDLE: if (!rx_dv) state_d = IDLE;
      IDLE: if (dv_q) begin
        start = 1'b1;
        if (rxd_q == PRE_OCTET)      state_d = PRE;
        else if (rxd_q == SFD_OCTET) state_d = DATA;
        else begin
          state_d     = DROP;
          set_err_pre = 1'b1;
        end
      end
      PRE: begin
        if (!dv_q) begin
          end_frame   = 1'b1;
          set_err_pre = 1'b1;
          state_d     = IDLE;
        end else if (rxd_q == PRE_OCTET) begin
          if (pre_cnt >= PRE_W'(MAX_PRE)) begin
            set_err_pre = 1'b1;
            state_d     = DROP;
          end else begin
            pre_inc = 1'b1;
          end
        end else if (rxd_q == SFD_OCTET) begin
          state_d = DATA;
        end else begin
          set_err_pre = 1'b1;
          state_d     = DROP;
        end
      end
      DATA: begin
        emit = hold_vld;
        if (dv_q) begin
          load_hold = 1'b1;
          len_inc   = 1'b1;
        end else begin
          emit_eof  = 1'b1;
          end_frame = 1'b1;
          state_d   = IDLE;
        end
      end
      DROP: begin
        if (dv_q) begin
          len_inc = 1'b1;
        end else begin
          end_frame = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = WAIT_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge mr_main_reset) begin
    if (!mr_main_reset) begin
      rxd_q       <= '0;
      dv_q        <= 1'b0;
      er_q        <= 1'b0;
      hold_dat    <= '0;
      hold_vld    <= 1'b0;
      sof_pend    <= 1'b0;
      pre_cnt     <= '0;
      len_cnt     <= '0;
      acc_err_pre <= 1'b0;
      acc_err_rx  <= 1'b0;
      data_out    <= '0;
      data_valid  <= 1'b0;
      sof         <= 1'b0;
      eof         <= 1'b0;
      frame_done  <= 1'b0;
      frame_len   <= '0;
      err_pre     <= 1'b0;
      err_rx      <= 1'b0;
      err_short   <= 1'b0;
      err_long    <= 1'b0;
      good_cnt    <= '0;
      bad_cnt     <= '0;
    end else begin
      rxd_q <= rxd;
      dv_q  <= rx_dv;
      er_q  <= rx_er;

      if (start) begin
        pre_cnt     <= PRE_W'(1);
        len_cnt     <= '0;
        acc_err_pre <= set_err_pre;
        acc_err_rx  <= 1'b0;
        hold_vld    <= 1'b0;
        sof_pend    <= 1'b1;
      end else begin
        if (pre_inc) pre_cnt <= pre_cnt + PRE_W'(1);
        if (len_inc && len_cnt != LEN_SAT) len_cnt <= len_cnt + LEN_ONE;
        if (set_err_pre) acc_err_pre <= 1'b1;
        if (in_frame && dv_q && er_q) acc_err_rx <= 1'b1;
        if (emit) sof_pend <= 1'b0;
        if (load_hold) begin
          hold_dat <= rxd_q;
          hold_vld <= 1'b1;
        end else if (end_frame) begin
          hold_vld <= 1'b0;
        end
      end

      data_valid <= emit;
      sof        <= emit & sof_pend;
      eof        <= emit & emit_eof;
      if (emit) data_out <= hold_dat;

      frame_done <= end_frame;
      if (end_frame) begin
        frame_len <= len_cnt;
        err_pre   <= fin_err_pre;
        err_rx    <= acc_err_rx;
        err_short <= fin_short;
        err_long  <= fin_long;
        if (fin_bad) bad_cnt  <= bad_cnt + LEN_ONE;
        else         good_cnt <= good_cnt + LEN_ONE;
      end
    end
  end

endmodule

// File: tb/tb_gmii_rx_frame_checker.sv
// Randomised + directed bench: frames are described as octet lists, a high-level model derives payload and status.
module tb_gmii_rx_frame_checker;
  localparam int MIN_LEN = 64;
  localparam int MAX_LEN = 1518;
  localparam int MAX_PRE = 7;

  logic        clk = 1'b0;
  logic        mr_main_reset;
  logic [7:0]  rxd;
  logic        rx_dv, rx_er;
  logic [7:0]  data_out;
  logic        data_valid, sof, eof, frame_done;
  logic [15:0] frame_len, good_cnt, bad_cnt;
  logic        err_pre, err_rx, err_short, err_long;

  gmii_rx_frame_checker #(
    .OCTET_WIDTH(8), .LEN_WIDTH(16), .MIN_LEN(MIN_LEN), .MAX_LEN(MAX_LEN), .MAX_PRE(MAX_PRE)
  ) dut (
    .clk(clk), .mr_main_reset(mr_main_reset), .rxd(rxd), .rx_dv(rx_dv), .rx_er(rx_er),
    .data_out(data_out), .data_valid(data_valid), .sof(sof), .eof(eof),
    .frame_done(frame_done), .frame_len(frame_len), .err_pre(err_pre), .err_rx(err_rx),
    .err_short(err_short), .err_long(err_long), .good_cnt(good_cnt), .bad_cnt(bad_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {logic [7:0] d; logic sof; logic eof;} oct_t;
  typedef struct packed {
    logic [15:0] len; logic ep; logic er; logic es; logic el; logic [15:0] good; logic [15:0] bad;
  } rep_t;

  oct_t       exp_q[$];
  rep_t       rep_q[$];
  logic [7:0] tx_oct[$];
  bit         tx_er[$];
  int checks = 0, errors = 0;
  int good_m = 0, bad_m = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] outvec();
    return {data_out, data_valid, sof, eof, frame_done, frame_len,
            err_pre, err_rx, err_short, err_long, good_cnt, bad_cnt};
  endfunction

  // Reference model: locate the SFD by counting leading preamble octets, then derive payload and status.
  task automatic model_push();
    int n, idx, len, first, sz;
    bit ok, erx, bad;
    rep_t r;
    sz = tx_oct.size();
    n = 0;
    while (n < sz && tx_oct[n] == 8'h55) n++;
    ok = (n <= MAX_PRE) && (n < sz) && (tx_oct[n] == 8'hD5);
    if (ok) begin
      first = n + 1;
      len = sz - first;
      for (int i = first; i < sz; i++)
        exp_q.push_back('{d: tx_oct[i], sof: (i == first), eof: (i == sz - 1)});
    end else begin
      idx = (n < MAX_PRE) ? n : MAX_PRE;
      len = (idx >= sz) ? 0 : sz - idx - 1;
    end
    if (len > 65535) len = 65535;
    erx = 1'b0;
    for (int i = 1; i < tx_er.size(); i++) if (tx_er[i]) erx = 1'b1;
    bad = !ok || erx || (len < MIN_LEN) || (len > MAX_LEN);
    if (bad) bad_m++; else good_m++;
    r.len = 16'(len); r.ep = !ok; r.er = erx;
    r.es = (len < MIN_LEN); r.el = (len > MAX_LEN);
    r.good = 16'(good_m); r.bad = 16'(bad_m);
    rep_q.push_back(r);
  endtask

  // base < 0 means random payload; er_idx < 0 means no rx_er in the payload.
  task automatic build(input int npre, input logic [7:0] sfd, input int plen, input int base, input int er_idx);
    logic [7:0] b;
    tx_oct.delete();
    tx_er.delete();
    for (int i = 0; i < npre; i++) begin tx_oct.push_back(8'h55); tx_er.push_back(1'b0); end
    tx_oct.push_back(sfd);
    tx_er.push_back(1'b0);
    for (int i = 0; i < plen; i++) begin
      b = (base < 0) ? 8'($urandom) : 8'(base + i);
      tx_oct.push_back(b);
      tx_er.push_back(i == er_idx);
    end
  endtask

  task automatic drive_gap(input int gap, input bit gap_er);
    for (int g = 0; g < gap; g++) begin
      @(posedge clk); #1;
      rxd = 8'($urandom); rx_dv = 1'b0; rx_er = gap_er & 1'($urandom_range(0, 1));
    end
  endtask

  task automatic send_frame(input int gap, input bit gap_er);
    model_push();
    for (int i = 0; i < tx_oct.size(); i++) begin
      @(posedge clk); #1;
      rxd = tx_oct[i]; rx_dv = 1'b1; rx_er = tx_er[i];
    end
    drive_gap(gap, gap_er);
  endtask

  task automatic wait_drain();
    int k = 0;
    while ((exp_q.size() != 0 || rep_q.size() != 0) && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    check("drain", 64'(exp_q.size() + rep_q.size()), 64'd0);
  endtask

  always @(negedge clk) begin
    oct_t e;
    rep_t r, a;
    if (data_valid) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_octet: got %0h with no octet expected", data_out);
      end else begin
        e = exp_q.pop_front();
        check("payload", 64'({data_out, sof, eof}), 64'(e));
      end
    end
    if (frame_done) begin
      a = '{len: frame_len, ep: err_pre, er: err_rx, es: err_short, el: err_long,
            good: good_cnt, bad: bad_cnt};
      if (rep_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_frame_done: got %0h with no report expected", a);
      end else begin
        r = rep_q.pop_front();
        check("frame_report", 64'(a), 64'(r));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [7:0] b;
    int npre, plen, eri;
    rxd = 8'h00; rx_dv = 1'b0; rx_er = 1'b0; mr_main_reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", outvec(), 64'd0);
    mr_main_reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Good 64-octet frame.
    build(7, 8'hD5, 64, 0, -1);
    send_frame(3, 1'b0);
    // Short preamble, two back-to-back short frames.
    build(1, 8'hD5, 10, 8'h40, -1);
    send_frame(1, 1'b0);
    build(1, 8'hD5, 10, 8'h80, -1);
    send_frame(3, 1'b0);
    // Bad SFD.
    build(2, 8'h5D, 20, 0, -1);
    send_frame(3, 1'b0);
    // rx_er mid payload, then rx_er with rx_dv low between frames.
    build(7, 8'hD5, 100, 0, 50);
    send_frame(6, 1'b1);
    wait_drain();
    check("idle_er_counters", 64'({good_cnt, bad_cnt}), 64'({16'(good_m), 16'(bad_m)}));
    // Oversized frame.
    build(7, 8'hD5, 1519, -1, -1);
    send_frame(3, 1'b0);
    // Random frames.
    for (int f = 0; f < 40; f++) begin
      npre = $urandom_range(0, 8);
      plen = $urandom_range(0, 80);
      eri = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 80) : -1;
      if ($urandom_range(0, 5) == 0) begin
        do b = 8'($urandom); while (b == 8'h55 || b == 8'hD5);
      end else begin
        b = 8'hD5;
      end
      build(npre, b, plen, -1, eri);
      send_frame($urandom_range(1, 3), 1'($urandom_range(0, 1)));
    end
    wait_drain();

    // Reset at payload octet 30; rx_dv stays high for 20 more octets.
    build(7, 8'hD5, 51, 0, -1);
    model_push();
    for (int i = 0; i < tx_oct.size(); i++) begin
      @(posedge clk); #1;
      rxd = tx_oct[i]; rx_dv = 1'b1; rx_er = 1'b0;
      if (i == 38) begin
        mr_main_reset = 1'b0;
        exp_q.delete();
        rep_q.delete();
        good_m = 0;
        bad_m = 0;
        #1;
        check("reset_assert_clears", outvec(), 64'd0);
      end
      if (i == 39) mr_main_reset = 1'b1;
    end
    drive_gap(3, 1'b0);
    build(7, 8'hD5, 64, 8'h10, -1);
    send_frame(3, 1'b0);
    wait_drain();
    check("post_reset_counters", 64'({good_cnt, bad_cnt, frame_len}), 64'({16'd1, 16'd0, 16'd64}));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
